// File: rtl/lockstep_pkg.sv
// Shared types for the lockstep scheduler: FSM state encoding and the per-copy
// observation bundle compared between the two core copies.
package lockstep_pkg;

   localparam int OBS_MAX_W = 64;
   localparam int PCSEL_W   = 3;

   typedef enum logic [1:0] {
      LOCK  = 2'd0,
      HOLD1 = 2'd1,
      HOLD2 = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Fields are sized for the widest supported OBS_W; narrower builds zero-extend.
   typedef struct packed {
      logic                 mem_v;
      logic [OBS_MAX_W-1:0] mem_addr;
      logic [OBS_MAX_W-1:0] npc;
      logic [PCSEL_W-1:0]   pcsel;
   } obs_t;

   function automatic obs_t make_obs(input logic                 mem_v,
                                     input logic [OBS_MAX_W-1:0] mem_addr,
                                     input logic [OBS_MAX_W-1:0] npc,
                                     input logic [PCSEL_W-1:0]   pcsel);
      obs_t o;
      o.mem_v    = mem_v;
      o.mem_addr = mem_addr;
      o.npc      = npc;
      o.pcsel    = pcsel;
      return o;
   endfunction

endpackage

// File: rtl/lockstep_if.sv
// Signal bundle between the two core copies and the lockstep scheduler.
// master = core/environment side, slave = scheduler side.
interface lockstep_if #(
   parameter int OBS_W = 32,
   parameter int CNT_W = 32
);
   // commit_x acts as a valid from copy x; en_x is its back-pressure: a copy whose
   // en_x is low does not advance, so a commit_x seen while en_x=0 is not a new
   // retirement and the scheduler ignores it for release decisions.
   logic             commit_1;
   logic             commit_2;
   logic             mem_v_1;
   logic             mem_v_2;
   logic [OBS_W-1:0] mem_addr_1;
   logic [OBS_W-1:0] mem_addr_2;
   logic [OBS_W-1:0] npc_1;
   logic [OBS_W-1:0] npc_2;
   logic [2:0]       pcsel_1;
   logic [2:0]       pcsel_2;

   logic             en_1;
   logic             en_2;
   logic             commit_dev;
   logic             addr_dev;
   logic             invalid_prog;
   logic             timeout;
   logic             finish_1;
   logic             finish_2;
   logic             done;
   logic [CNT_W-1:0] total_cnt;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output commit_1, commit_2, mem_v_1, mem_v_2, mem_addr_1, mem_addr_2,
             npc_1, npc_2, pcsel_1, pcsel_2,
      input  en_1, en_2, commit_dev, addr_dev, invalid_prog, timeout,
             finish_1, finish_2, done, total_cnt, stall_cnt
   );

   modport slave (
      input  commit_1, commit_2, mem_v_1, mem_v_2, mem_addr_1, mem_addr_2,
             npc_1, npc_2, pcsel_1, pcsel_2,
      output en_1, en_2, commit_dev, addr_dev, invalid_prog, timeout,
             finish_1, finish_2, done, total_cnt, stall_cnt
   );

endinterface

// File: rtl/lockstep_obs_cmp.sv
// Observation comparator: addresses only matter when both sides issue a memory
// request; next-PC and PC-select must always agree.
module lockstep_obs_cmp
   import lockstep_pkg::*;
(
   input  obs_t obs_a,
   input  obs_t obs_b,
   output logic mismatch
);

   logic addr_mis;
   logic flow_mis;

   assign addr_mis = obs_a.mem_v && obs_b.mem_v && (obs_a.mem_addr != obs_b.mem_addr);
   assign flow_mis = (obs_a.npc != obs_b.npc) || (obs_a.pcsel != obs_b.pcsel);
   assign mismatch = addr_mis || flow_mis;

endmodule

// File: rtl/lockstep_sched.sv
// Lockstep scheduler: keeps two core copies in step, freezing whichever copy
// retires first until the other catches up. Counters built with LOCKSTEP_PERF_CNT_EN.
module lockstep_sched
   import lockstep_pkg::*;
#(
   parameter int OBS_W     = 32,
   parameter int MAX_STALL = 64,
   parameter int CNT_W     = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   lockstep_if.slave bus,
   output state_e    dbg_state
);

   localparam int              HC_W      = $clog2(MAX_STALL + 1);
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_STALL - 1);
   localparam logic [HC_W-1:0] HOLD_MAX  = HC_W'(MAX_STALL);

   state_e           state_q, state_d;
   obs_t             snap_q, snap_d;
   logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic             en_1_q, en_1_d, en_2_q, en_2_d, done_q, done_d;
   logic             commit_dev_q, commit_dev_d;
   logic             addr_dev_q, addr_dev_d;
   logic             invalid_prog_q, invalid_prog_d;
   logic             timeout_q, timeout_d;
   logic             finish_1_q, finish_1_d;
   logic             finish_2_q, finish_2_d;

   obs_t             obs_1, obs_2, live_obs;
   logic             lock_mis, snap_mis, active, release_c, stop_c;
   logic [OBS_W-1:0] eff_addr_1, eff_addr_2;

   assign obs_1 = make_obs(bus.mem_v_1, OBS_MAX_W'(bus.mem_addr_1),
                           OBS_MAX_W'(bus.npc_1), bus.pcsel_1);
   assign obs_2 = make_obs(bus.mem_v_2, OBS_MAX_W'(bus.mem_addr_2),
                           OBS_MAX_W'(bus.npc_2), bus.pcsel_2);

   // The frozen leader's snapshot is checked against whichever copy is catching up.
   assign live_obs = (state_q == HOLD1) ? obs_2 : obs_1;

   lockstep_obs_cmp u_lock_cmp (
      .obs_a   (obs_1),
      .obs_b   (obs_2),
      .mismatch(lock_mis)
   );

   lockstep_obs_cmp u_snap_cmp (
      .obs_a   (snap_q),
      .obs_b   (live_obs),
      .mismatch(snap_mis)
   );

   assign eff_addr_1 = bus.mem_v_1 ? bus.mem_addr_1 : '0;
   assign eff_addr_2 = bus.mem_v_2 ? bus.mem_addr_2 : '0;
   assign active     = (state_q != DONE);
   assign release_c  = (state_q == HOLD1) ? bus.commit_2 : bus.commit_1;
   assign stop_c     = invalid_prog_q || timeout_q || (finish_1_q && finish_2_q);

   always_comb begin
      state_d        = state_q;
      snap_d         = snap_q;
      hold_cnt_d     = hold_cnt_q;
      commit_dev_d   = commit_dev_q;
      addr_dev_d     = addr_dev_q;
      invalid_prog_d = invalid_prog_q;
      timeout_d      = timeout_q;
      finish_1_d     = finish_1_q;
      finish_2_d     = finish_2_q;

      if (active) begin
         if (!commit_dev_q && (eff_addr_1 != eff_addr_2)) addr_dev_d = 1'b1;
         if ((commit_dev_q || addr_dev_q) && bus.commit_1 && en_1_q) finish_1_d = 1'b1;
         if ((commit_dev_q || addr_dev_q) && bus.commit_2 && en_2_q) finish_2_d = 1'b1;

         if (stop_c) begin
            state_d = DONE;
         end else begin
            case (state_q)
               LOCK: begin
                  hold_cnt_d = '0;
                  if (bus.commit_1 && bus.commit_2) begin
                     if (lock_mis) invalid_prog_d = 1'b1;
                  end else if (bus.commit_1) begin
                     snap_d       = obs_1;
                     commit_dev_d = 1'b1;
                     state_d      = HOLD1;
                  end else if (bus.commit_2) begin
                     snap_d       = obs_2;
                     commit_dev_d = 1'b1;
                     state_d      = HOLD2;
                  end
               end
               HOLD1, HOLD2: begin
                  // A releasing commit beats a timeout landing in the same cycle.
                  if (release_c) begin
                     if (snap_mis) invalid_prog_d = 1'b1;
                     hold_cnt_d = '0;
                     state_d    = LOCK;
                  end else if (hold_cnt_q == HOLD_LAST) begin
                     hold_cnt_d = HOLD_MAX;
                     timeout_d  = 1'b1;
                     state_d    = DONE;
                  end else begin
                     hold_cnt_d = hold_cnt_q + HC_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end

      en_1_d = (state_d == LOCK) || (state_d == HOLD2);
      en_2_d = (state_d == LOCK) || (state_d == HOLD1);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= LOCK;
         snap_q         <= '0;
         hold_cnt_q     <= '0;
         en_1_q         <= 1'b1;
         en_2_q         <= 1'b1;
         done_q         <= 1'b0;
         commit_dev_q   <= 1'b0;
         addr_dev_q     <= 1'b0;
         invalid_prog_q <= 1'b0;
         timeout_q      <= 1'b0;
         finish_1_q     <= 1'b0;
         finish_2_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         snap_q         <= snap_d;
         hold_cnt_q     <= hold_cnt_d;
         en_1_q         <= en_1_d;
         en_2_q         <= en_2_d;
         done_q         <= done_d;
         commit_dev_q   <= commit_dev_d;
         addr_dev_q     <= addr_dev_d;
         invalid_prog_q <= invalid_prog_d;
         timeout_q      <= timeout_d;
         finish_1_q     <= finish_1_d;
         finish_2_q     <= finish_2_d;
      end
   end

`ifdef LOCKSTEP_PERF_CNT_EN
   logic [CNT_W-1:0] total_cnt_q, total_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             in_hold;

   assign in_hold = (state_q == HOLD1) || (state_q == HOLD2);

   // Both counters saturate and stop once the pair has reached DONE.
   always_comb begin
      total_cnt_d = total_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (active) begin
         if (total_cnt_q != '1) total_cnt_d = total_cnt_q + CNT_W'(1);
         if (in_hold && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         total_cnt_q <= total_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.total_cnt = total_cnt_q;
   assign bus.stall_cnt = stall_cnt_q;
`else
   assign bus.total_cnt = '0;
   assign bus.stall_cnt = '0;
`endif

   assign bus.en_1         = en_1_q;
   assign bus.en_2         = en_2_q;
   assign bus.done         = done_q;
   assign bus.commit_dev   = commit_dev_q;
   assign bus.addr_dev     = addr_dev_q;
   assign bus.invalid_prog = invalid_prog_q;
   assign bus.timeout      = timeout_q;
   assign bus.finish_1     = finish_1_q;
   assign bus.finish_2     = finish_2_q;
   assign dbg_state        = state_q;

endmodule
